// File: rtl/mem_access_unit_if.sv
// Request, response and SRAM port bundle for the data-memory access unit.
// The CPU side acts as master; the access unit is the slave on the request
// channel and the initiator on the SRAM signals.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The sender keeps its payload
// stable while valid is high and ready is low. Ready may not depend on valid.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;

    logic [7:0]  mem_w_en;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_w_en, mem_address, mem_write_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_w_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: takes one RV64I load/store at a time, rejects
// misaligned or illegal-funct3 requests without touching memory, drives the
// byte-addressed SRAM for one cycle, and returns extended load data or a
// store acknowledge on the response channel.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        error_q;

    logic        accept;
    logic        misaligned;
    logic        req_err;

    // SRAM write-size code from the access size (funct3[1:0]).
    function automatic logic [7:0] size_code(input logic [1:0] sz);
        logic [7:0] code;
        unique case (sz)
            2'b00:   code = 8'b0000_0001;
            2'b01:   code = 8'b0000_0011;
            2'b10:   code = 8'b0000_1111;
            default: code = 8'b1111_1111;
        endcase
        return code;
    endfunction

    // Sign/zero extension of the raw SRAM word according to the load type.
    function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] raw);
        logic [63:0] res;
        case (f3)
            3'b000:  res = {{56{raw[7]}},  raw[7:0]};
            3'b001:  res = {{48{raw[15]}}, raw[15:0]};
            3'b010:  res = {{32{raw[31]}}, raw[31:0]};
            3'b011:  res = raw;
            3'b100:  res = {56'd0, raw[7:0]};
            3'b101:  res = {48'd0, raw[15:0]};
            3'b110:  res = {32'd0, raw[31:0]};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    assign accept = (state == IDLE) && bus.req_valid;

    // Request legality: alignment against the access size plus funct3 encoding.
    always_comb begin
        misaligned = 1'b0;
        unique case (bus.req_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = |bus.req_addr[2:0];
        endcase
        req_err = misaligned
                | (bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: errors skip the memory cycle entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_err ? RESP : ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    if (bus.resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch and response capture; only an accepted request updates the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            error_q  <= 1'b0;
        end else if (accept) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 64'd0;
            error_q  <= req_err;
        end else if (state == ACCESS) begin
            rdata_q  <= we_q ? 64'd0 : load_extend(funct3_q, bus.mem_read_data);
        end
    end

    // Write enable decoded from state so an asserted reset removes it at once.
    always_comb begin
        bus.mem_w_en = 8'd0;
        if ((state == ACCESS) && we_q) begin
            bus.mem_w_en = size_code(funct3_q[1:0]);
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_error     = error_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign dbg_state          = state;
endmodule
